orion_mmu_wait: RTL and testbench



---
 rtl/orion_mmu_pkg.sv | 21 ++
 rtl/orion_mmu_wait_gen.sv | 76 +++++++
 rtl/orion_mmu_wait.sv | 139 +++++++++++++
 tb/tb_orion_mmu_wait.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/orion_mmu_pkg.sv
// Shared constants and types for the Orion MMU / wait-state unit.
package orion_mmu_pkg;

  // CTRL register bit positions
  localparam int CTRL_MAP_EN = 0;
  localparam int CTRL_WS_LSB = 1;
  localparam int CTRL_FAULT  = 7;

  // Page register write-protect bit
  localparam int PG_WP_BIT = 7;

  localparam logic [7:0] DEF_IO_BASE   = 8'h08;
  localparam logic [7:0] DEF_CTRL_PORT = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD
  } wait_state_e;

endpackage

// File: rtl/orion_mmu_wait_gen.sv
// Wait-state generator: holds CPU WAIT low for a programmed number of clocks
// once per memory access.
module orion_wait_gen
  import orion_mmu_pkg::*;
#(
  parameter int WS_W = 3
) (
  input  logic            i_clk,
  input  logic            reset_n,
  input  logic            mem_acc_i,
  input  logic            mreq_n_i,
  input  logic [WS_W-1:0] ws_i,
  output logic            wait_n_o
);

  localparam logic [WS_W-1:0] ONE = WS_W'(1);

  wait_state_e     state_q, state_d;
  logic [WS_W-1:0] cnt_q, cnt_d;
  logic            wait_n_q, wait_n_d;

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wait_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_n_q <= wait_n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_n_d = wait_n_q;
    case (state_q)
      ST_IDLE: begin
        wait_n_d = 1'b1;
        if (mem_acc_i) begin
          // WS is captured here, so later CTRL writes leave this access alone
          if (ws_i != '0) begin
            state_d  = ST_WAIT;
            cnt_d    = ws_i - ONE;
            wait_n_d = 1'b0;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        if (mreq_n_i) begin
          state_d  = ST_IDLE;
          wait_n_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d  = ST_HOLD;
          wait_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_HOLD: begin
        wait_n_d = 1'b1;
        if (mreq_n_i) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        wait_n_d = 1'b1;
      end
    endcase
  end

  assign wait_n_o = wait_n_q;

endmodule

// File: rtl/orion_mmu_wait.sv
// Orion windowed MMU with write protect and programmable wait states.
// Optional register read-back is enabled by defining ORION_MMU_READBACK_EN.
module orion_mmu_wait
  import orion_mmu_pkg::*;
#(
  parameter int         WIN_BITS  = 2,
  parameter int         PAGE_W    = 7,
  parameter int         PHYS_AW   = PAGE_W + 16 - WIN_BITS,
  parameter logic [7:0] IO_BASE   = DEF_IO_BASE,
  parameter logic [7:0] CTRL_PORT = DEF_CTRL_PORT,
  parameter int         WS_W      = 3
) (
  input  logic               i_clk,
  input  logic               reset_n,
  input  logic               i_mreq_n,
  input  logic               i_iorq_n,
  input  logic               i_rd_n,
  input  logic               i_wr_n,
  input  logic               i_rfsh_n,
  input  logic [15:0]        i_addr,
  input  logic [7:0]         i_wdata,
  output logic [7:0]         o_rdata,
  output logic               o_rdata_oe,
  output logic               o_wait_n,
  output logic [PHYS_AW-1:0] o_mem_addr,
  output logic               o_mem_rd,
  output logic               o_mem_wr,
  output logic               o_wp_fault
);

  localparam int NWIN  = 1 << WIN_BITS;
  localparam int OFF_W = 16 - WIN_BITS;

  logic [PAGE_W-1:0]   page_q [NWIN];
  logic [PAGE_W-1:0]   page_d [NWIN];
  logic [NWIN-1:0]     wp_q, wp_d;
  logic                map_en_q, map_en_d;
  logic [WS_W-1:0]     ws_q, ws_d;
  logic                fault_q, fault_d;

  logic [WIN_BITS-1:0] win;
  logic                io_wr;
  logic                ctrl_sel;
  logic                mem_acc;
  logic                wp_hit;

  assign win      = i_addr[15:OFF_W];
  assign io_wr    = ~i_iorq_n & ~i_wr_n;
  assign ctrl_sel = (i_addr[7:0] == CTRL_PORT);
  assign mem_acc  = ~i_mreq_n & i_rfsh_n & (~i_rd_n | ~i_wr_n);
  assign wp_hit   = map_en_q & wp_q[win];

  assign o_mem_rd = mem_acc & ~i_rd_n;
  assign o_mem_wr = mem_acc & ~i_wr_n & ~wp_hit;

  always_comb begin
    if (map_en_q) o_mem_addr = {page_q[win], i_addr[OFF_W-1:0]};
    else          o_mem_addr = PHYS_AW'(i_addr);
  end

  always_comb begin
    page_d   = page_q;
    wp_d     = wp_q;
    map_en_d = map_en_q;
    ws_d     = ws_q;
    fault_d  = fault_q;
    for (int i = 0; i < NWIN; i++) begin
      if (io_wr && (i_addr[7:0] == IO_BASE + 8'(i))) begin
        page_d[i] = i_wdata[PAGE_W-1:0];
        wp_d[i]   = i_wdata[PG_WP_BIT];
      end
    end
    if (io_wr && ctrl_sel) begin
      map_en_d = i_wdata[CTRL_MAP_EN];
      ws_d     = i_wdata[CTRL_WS_LSB +: WS_W];
      if (i_wdata[CTRL_FAULT]) fault_d = 1'b0;
    end
    // A violation on the same edge as a clear must not be lost
    if (mem_acc && !i_wr_n && wp_hit) fault_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NWIN; i++) page_q[i] <= PAGE_W'(i);
      wp_q     <= '0;
      map_en_q <= 1'b0;
      ws_q     <= '0;
      fault_q  <= 1'b0;
    end else begin
      page_q   <= page_d;
      wp_q     <= wp_d;
      map_en_q <= map_en_d;
      ws_q     <= ws_d;
      fault_q  <= fault_d;
    end
  end

  assign o_wp_fault = fault_q;

`ifdef ORION_MMU_READBACK_EN
  logic io_rd;
  assign io_rd = ~i_iorq_n & ~i_rd_n;

  always_comb begin
    o_rdata    = '0;
    o_rdata_oe = 1'b0;
    if (io_rd) begin
      if (ctrl_sel) begin
        o_rdata_oe                     = 1'b1;
        o_rdata[CTRL_MAP_EN]           = map_en_q;
        o_rdata[CTRL_WS_LSB +: WS_W]   = ws_q;
        o_rdata[CTRL_FAULT]            = fault_q;
      end
      for (int i = 0; i < NWIN; i++) begin
        if (i_addr[7:0] == IO_BASE + 8'(i)) begin
          o_rdata_oe           = 1'b1;
          o_rdata[PAGE_W-1:0]  = page_q[i];
          o_rdata[PG_WP_BIT]   = wp_q[i];
        end
      end
    end
  end
`else
  assign o_rdata    = '0;
  assign o_rdata_oe = 1'b0;
`endif

  orion_wait_gen #(
    .WS_W(WS_W)
  ) u_wait_gen (
    .i_clk    (i_clk),
    .reset_n  (reset_n),
    .mem_acc_i(mem_acc),
    .mreq_n_i (i_mreq_n),
    .ws_i     (ws_q),
    .wait_n_o (o_wait_n)
  );

endmodule

// File: tb/tb_orion_mmu_wait.sv
// Directed bench for orion_mmu_wait: mapping, strobes, write protect, wait FSM.
module tb_orion_mmu_wait;

  localparam int PHYS_AW = 21;

  logic               i_clk = 1'b0;
  logic               reset_n;
  logic               i_mreq_n, i_iorq_n, i_rd_n, i_wr_n, i_rfsh_n;
  logic [15:0]        i_addr;
  logic [7:0]         i_wdata;
  logic [7:0]         o_rdata;
  logic               o_rdata_oe;
  logic               o_wait_n;
  logic [PHYS_AW-1:0] o_mem_addr;
  logic               o_mem_rd, o_mem_wr, o_wp_fault;

  int n_cmp = 0;
  int n_err = 0;

  orion_mmu_wait dut (
    .i_clk     (i_clk),
    .reset_n   (reset_n),
    .i_mreq_n  (i_mreq_n),
    .i_iorq_n  (i_iorq_n),
    .i_rd_n    (i_rd_n),
    .i_wr_n    (i_wr_n),
    .i_rfsh_n  (i_rfsh_n),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .o_rdata   (o_rdata),
    .o_rdata_oe(o_rdata_oe),
    .o_wait_n  (o_wait_n),
    .o_mem_addr(o_mem_addr),
    .o_mem_rd  (o_mem_rd),
    .o_mem_wr  (o_mem_wr),
    .o_wp_fault(o_wp_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    i_mreq_n = 1'b1;
    i_iorq_n = 1'b1;
    i_rd_n   = 1'b1;
    i_wr_n   = 1'b1;
    i_rfsh_n = 1'b1;
    i_addr   = 16'h0000;
    i_wdata  = 8'h00;
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    i_iorq_n = 1'b0;
    i_wr_n   = 1'b0;
    i_addr   = {8'h00, port};
    i_wdata  = data;
    @(posedge i_clk); #1;
    bus_idle();
  endtask

  task automatic io_read_chk(input string tag, input logic [7:0] port, input logic [7:0] exp);
    i_iorq_n = 1'b0;
    i_rd_n   = 1'b0;
    i_addr   = {8'h00, port};
    #1;
`ifdef ORION_MMU_READBACK_EN
    check_eq({tag, "_oe"}, 32'(o_rdata_oe), 32'd1);
    check_eq(tag, 32'(o_rdata), 32'(exp));
`else
    check_eq({tag, "_oe"}, 32'(o_rdata_oe), 32'd0);
    check_eq(tag, 32'(o_rdata), 32'(exp & 8'h00));
`endif
    bus_idle();
    @(posedge i_clk); #1;
  endtask

  // Memory read held for 'edges' clocks; bit k of the pattern is WAIT low after edge k+1
  task automatic run_acc(input string tag, input logic [15:0] a, input logic [PHYS_AW-1:0] exp_addr,
                         input int edges, input logic [15:0] exp_pat);
    logic [15:0] pat;
    i_mreq_n = 1'b0;
    i_rd_n   = 1'b0;
    i_addr   = a;
    #1;
    check_eq({tag, "_addr"}, 32'(o_mem_addr), 32'(exp_addr));
    check_eq({tag, "_rd"}, 32'(o_mem_rd), 32'd1);
    pat = '0;
    for (int k = 0; k < edges; k++) begin
      @(posedge i_clk); #1;
      pat[k] = ~o_wait_n;
    end
    check_eq({tag, "_wait"}, 32'(pat), 32'(exp_pat));
    bus_idle();
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic [15:0] pat;
    bus_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("rst_wait_n", 32'(o_wait_n), 32'd1);
    check_eq("rst_fault", 32'(o_wp_fault), 32'd0);
    check_eq("rst_oe", 32'(o_rdata_oe), 32'd0);
    check_eq("rst_rdata", 32'(o_rdata), 32'd0);
    reset_n = 1'b1;

    // Unmapped read: identity address, no waits
    run_acc("unmapped", 16'h5123, 21'h05123, 4, 16'h0000);

    // Window 1 remapped to page 0x25
    io_write(8'h09, 8'h25);
    io_write(8'h0C, 8'h01);
    run_acc("win1", 16'h4010, 21'h94010, 3, 16'h0000);
    run_acc("win2", 16'h8123, 21'h08123, 2, 16'h0000);
    io_read_chk("rb_pg1", 8'h09, 8'h25);

    // WS=3: two accesses, each three wait clocks
    io_write(8'h0C, 8'h07);
    run_acc("ws3a", 16'h4010, 21'h94010, 8, 16'h0007);
    run_acc("ws3b", 16'h4010, 21'h94010, 8, 16'h0007);
    io_read_chk("rb_ctrl", 8'h0C, 8'h07);

    // Refresh cycle: no strobe, no wait
    i_mreq_n = 1'b0;
    i_rd_n   = 1'b0;
    i_rfsh_n = 1'b0;
    i_addr   = 16'h4010;
    #1;
    check_eq("rfsh_rd", 32'(o_mem_rd), 32'd0);
    pat = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk); #1;
      pat[k] = ~o_wait_n;
    end
    check_eq("rfsh_wait", 32'(pat), 32'd0);
    bus_idle();
    @(posedge i_clk); #1;

    // WS=5, MREQ released after two wait clocks
    io_write(8'h0C, 8'h0B);
    i_mreq_n = 1'b0;
    i_rd_n   = 1'b0;
    i_addr   = 16'h4010;
    pat = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge i_clk); #1;
      pat[k] = ~o_wait_n;
    end
    check_eq("abort_low", 32'(pat), 32'h3);
    bus_idle();
    @(posedge i_clk); #1;
    check_eq("abort_rel", 32'(o_wait_n), 32'd1);
    run_acc("ws5", 16'h4010, 21'h94010, 8, 16'h001F);

    // Write protect on window 3, page 0x10, WS=0
    io_write(8'h0B, 8'h90);
    io_write(8'h0C, 8'h01);
    i_mreq_n = 1'b0;
    i_wr_n   = 1'b0;
    i_addr   = 16'hC000;
    #1;
    check_eq("wp_wr", 32'(o_mem_wr), 32'd0);
    check_eq("wp_addr", 32'(o_mem_addr), 32'h40000);
    @(posedge i_clk); #1;
    check_eq("wp_set", 32'(o_wp_fault), 32'd1);
    bus_idle();
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("wp_sticky", 32'(o_wp_fault), 32'd1);
    io_read_chk("rb_fault", 8'h0C, 8'h81);
    io_write(8'h0C, 8'h81);
    check_eq("wp_clear", 32'(o_wp_fault), 32'd0);
    i_mreq_n = 1'b0;
    i_wr_n   = 1'b0;
    i_addr   = 16'h8000;
    #1;
    check_eq("unprot_wr", 32'(o_mem_wr), 32'd1);
    check_eq("unprot_addr", 32'(o_mem_addr), 32'h08000);
    @(posedge i_clk); #1;
    check_eq("unprot_fault", 32'(o_wp_fault), 32'd0);
    bus_idle();
    @(posedge i_clk); #1;

    // Protected write and fault clear on the same edge: set wins
    i_mreq_n = 1'b0;
    i_iorq_n = 1'b0;
    i_wr_n   = 1'b0;
    i_addr   = 16'hC00C;
    i_wdata  = 8'h81;
    @(posedge i_clk); #1;
    check_eq("set_wins", 32'(o_wp_fault), 32'd1);
    bus_idle();
    @(posedge i_clk); #1;
    io_write(8'h0C, 8'h80);
    check_eq("clr2", 32'(o_wp_fault), 32'd0);

    // Mapping off: write protect ignored
    i_mreq_n = 1'b0;
    i_wr_n   = 1'b0;
    i_addr   = 16'hC000;
    #1;
    check_eq("nomap_wr", 32'(o_mem_wr), 32'd1);
    check_eq("nomap_addr", 32'(o_mem_addr), 32'h0C000);
    @(posedge i_clk); #1;
    check_eq("nomap_fault", 32'(o_wp_fault), 32'd0);
    bus_idle();
    @(posedge i_clk); #1;

    // Reset in the middle of a WS=7 wait sequence
    io_write(8'h0A, 8'h33);
    io_write(8'h0C, 8'h0F);
    i_mreq_n = 1'b0;
    i_rd_n   = 1'b0;
    i_addr   = 16'h0100;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("ws7_low", 32'(o_wait_n), 32'd0);
    reset_n = 1'b0;
    @(posedge i_clk); #1;
    check_eq("mid_rst_wait", 32'(o_wait_n), 32'd1);
    bus_idle();
    reset_n = 1'b1;
    @(posedge i_clk); #1;
    check_eq("post_rst_wait", 32'(o_wait_n), 32'd1);
    io_read_chk("rb_pg2_rst", 8'h0A, 8'h02);
    run_acc("post_rst_map", 16'h8123, 21'h08123, 3, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
